// File: rtl/div_ctrl.sv
// div_ctrl -- reconfiguration sequencer in front of the even/odd clock dividers.
//
// Takes a requested divide factor over a valid/ready handshake, rejects
// illegal factors with a sticky error, and retunes the dividers safely:
// drop the enables, drain for SETTLE_CYCLES, pulse div_reset with the new
// factor already on div_n, then enable the even or odd divider. div_n is
// only updated while both enables are low.
//
// Optional build macro: DIV_BYPASS_EN. When defined, a factor of 1 is legal
// and ends in RUN with both dividers held in reset and bypass_sel=1.
// When undefined, bypass_sel is tied low and a factor of 1 is illegal.
//
// Ports:
//   clk         fast input clock, shared with the dividers
//   reset_n     asynchronous active-low reset
//   req_valid   new divide factor offered
//   req_n       requested divide factor
//   req_ready   request can be accepted this cycle
//   div_n       divide factor driven to both dividers
//   div_reset   active-high reset to both dividers
//   even_en     enable for the even divider
//   odd_en      enable for the odd divider
//   busy        reconfiguration in progress
//   err         sticky illegal-request flag
//   err_clr     clears err (a same-cycle illegal request wins)
//   bypass_sel  select the undivided clock
//
// state | meaning
// IDLE  | no factor loaded yet, dividers held in reset
// DRAIN | both enables low, waiting SETTLE_CYCLES before the reset pulse
// RST   | one-cycle div_reset pulse with the new div_n stable
// RUN   | one divider enabled (or bypass), ready for a new request

`ifndef SIZE
`define SIZE 8
`endif

module div_ctrl #(
  parameter int SIZE          = `SIZE,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  input  logic [SIZE-1:0] req_n,
  output logic            req_ready,
  output logic [SIZE-1:0] div_n,
  output logic            div_reset,
  output logic            even_en,
  output logic            odd_en,
  output logic            busy,
  output logic            err,
  input  logic            err_clr,
  output logic            bypass_sel
);

  typedef enum logic [1:0] {IDLE, DRAIN, RST, RUN} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       accept;
  logic       req_legal;
  logic       run_bypass;

  assign accept = req_valid && req_ready;

`ifdef DIV_BYPASS_EN
  assign req_legal  = (req_n != '0);
  assign run_bypass = (div_n == SIZE'(1));
`else
  // legal means req_n >= 2: any bit above bit 0 set
  assign req_legal  = (req_n[SIZE-1:1] != '0);
  assign run_bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_n     <= '0;
      div_reset <= 1'b1;
      even_en   <= 1'b0;
      odd_en    <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept && !req_legal) err <= 1'b1;
      else if (err_clr)         err <= 1'b0;

      case (state)
        IDLE, RUN: begin
          // illegal requests complete the handshake but leave the divider alone
          if (accept && req_legal) begin
            div_n     <= req_n;
            even_en   <= 1'b0;
            odd_en    <= 1'b0;
            cnt       <= SETTLE_LOAD;
            state     <= DRAIN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state     <= RST;
            div_reset <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RST: begin
          state     <= RUN;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (run_bypass) begin
            div_reset <= 1'b1;
          end else begin
            div_reset <= 1'b0;
            even_en   <= ~div_n[0];
            odd_en    <= div_n[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_BYPASS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    bypass_sel <= 1'b0;
    else if (accept && req_legal)    bypass_sel <= 1'b0;
    else if (state == RST && run_bypass) bypass_sel <= 1'b1;
  end
`else
  assign bypass_sel = 1'b0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
`ifndef SIZE
`define SIZE 8
`endif

module tb_div_ctrl;
  localparam int W = `SIZE;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic [W-1:0] req_n;
  logic         err_clr;
  logic         req_ready, div_reset, even_en, odd_en, busy, err, bypass_sel;
  logic [W-1:0] div_n;

  int checks = 0;
  int passed = 0;

  div_ctrl #(.SIZE(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready), .div_n(div_n), .div_reset(div_reset),
    .even_en(even_en), .odd_en(odd_en), .busy(busy), .err(err),
    .err_clr(err_clr), .bypass_sel(bypass_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit legal(input logic [W-1:0] n);
`ifdef DIV_BYPASS_EN
    return n >= 1;
`else
    return n >= 2;
`endif
  endfunction

  // Timeline model: outputs are a function of how many cycles have elapsed
  // since the last legal acceptance edge.
  int           e = 0;
  int           acc_edge = 0;
  bit           in_seq = 0;
  logic [W-1:0] m_n = '0;
  logic m_reset = 1, m_even = 0, m_odd = 0, m_ready = 1, m_busy = 0;
  logic m_err = 0, m_byp = 0, pre_reset = 1;

  always @(posedge clk) begin : model_blk
    int j;
    e++;
    if (!reset_n) begin
      m_n = '0; m_reset = 1; m_even = 0; m_odd = 0; m_ready = 1;
      m_busy = 0; m_err = 0; m_byp = 0; in_seq = 0;
    end else begin
      if (req_valid && m_ready && !legal(req_n)) m_err = 1;
      else if (err_clr) m_err = 0;
      if (req_valid && m_ready && legal(req_n)) begin
        m_n = req_n; acc_edge = e; in_seq = 1; m_byp = 0; pre_reset = m_reset;
      end
      if (in_seq) begin
        j = e - acc_edge + 1;
        m_ready = 0; m_busy = 1; m_even = 0; m_odd = 0;
        if (j <= S) m_reset = pre_reset;
        else if (j == S + 1) m_reset = 1;
        else begin
          in_seq = 0; m_ready = 1; m_busy = 0;
          if (m_n == 1) begin
            m_reset = 1; m_byp = 1;
          end else begin
            m_reset = 0; m_even = !m_n[0]; m_odd = m_n[0];
          end
        end
      end
    end
    #1;
    chk("mdl_ready", req_ready, m_ready);
    chk("mdl_div_n", div_n, m_n);
    chk("mdl_div_reset", div_reset, m_reset);
    chk("mdl_even_en", even_en, m_even);
    chk("mdl_odd_en", odd_en, m_odd);
    chk("mdl_busy", busy, m_busy);
    chk("mdl_err", err, m_err);
    chk("mdl_bypass", bypass_sel, m_byp);
    chk("inv_both_en", even_en & odd_en, 0);
    chk("inv_en_in_reset", div_reset & (even_en | odd_en), 0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Offer one request; returns at the negedge of cycle k+1.
  task automatic send(input int n);
    req_valid = 1'b1;
    req_n = W'(n);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_n = '0; err_clr = 1'b0;
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_div_n", div_n, 0);
    chk("rst_div_reset", div_reset, 1);
    chk("rst_en", {even_en, odd_en}, 0);
    chk("rst_busy_err_byp", {busy, err, bypass_sel}, 0);
    reset_n = 1'b1;
    step();

    send(6);                                  // k+1
    chk("n6_k1_ready", req_ready, 0);
    chk("n6_k1_div_n", div_n, 6);
    step();                                   // k+2
    chk("n6_k2_ready", req_ready, 0);
    step();                                   // k+3
    chk("n6_k3_div_reset", div_reset, 1);
    chk("n6_k3_ready", req_ready, 0);
    step();                                   // k+4
    chk("n6_k4_en", {even_en, odd_en}, 2'b10);
    chk("n6_k4_busy", busy, 0);
    chk("n6_k4_div_reset", div_reset, 0);

    send(7);
    chk("n7_k1_even", even_en, 0);
    chk("n7_k1_div_reset", div_reset, 0);
    step(); step();
    chk("n7_k3_div_reset", div_reset, 1);
    step();
    chk("n7_k4_en", {even_en, odd_en}, 2'b01);
    chk("n7_k4_div_n", div_n, 7);

    send(4); repeat (3) step();
    chk("n4_even", even_en, 1);
    send(0);
    chk("ill0_err", err, 1);
    chk("ill0_even", even_en, 1);
    chk("ill0_div_n", div_n, 4);
`ifndef DIV_BYPASS_EN
    err_clr = 1'b1;
    send(1);
    err_clr = 1'b0;
    chk("ill1_set_wins", err, 1);
    chk("ill1_div_n", div_n, 4);
`endif
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr", err, 0);

    send(9);
    chk("drain_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ready", req_ready, 1);
    chk("async_rst_div_n", div_n, 0);
    chk("async_rst_div_reset", div_reset, 1);
    chk("async_rst_busy", busy, 0);
    step(); reset_n = 1'b1; step();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_div_reset", div_reset, 1);
    chk("post_rst_en", {even_en, odd_en}, 0);

    req_valid = 1'b1; req_n = W'(10); step();
    req_n = W'(11); step();
    req_n = W'(12); step();
    chk("hold_k3_div_n", div_n, 10);
    req_n = W'(13); step();
    chk("hold_k4_div_n", div_n, 10);
    chk("hold_k4_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("hold_next_div_n", div_n, 13);
    chk("hold_next_ready", req_ready, 0);
    repeat (3) step();
    chk("hold_next_odd", odd_en, 1);

    send(13);
    chk("same_k1_odd", odd_en, 0);
    repeat (3) step();
    chk("same_k4_odd", odd_en, 1);

`ifdef DIV_BYPASS_EN
    send(1); repeat (3) step();
    chk("byp_sel", bypass_sel, 1);
    chk("byp_en", {even_en, odd_en}, 0);
    chk("byp_div_reset", div_reset, 1);
    send(5);
    chk("byp_clear_k1", bypass_sel, 0);
    repeat (3) step();
    chk("byp_n5_odd", odd_en, 1);
`endif

    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Control stage directly upstream of the even and odd dividers in the adjustable clock divider.
- Accepts a requested divide factor over a valid/ready handshake and validates it.
- Sequences a safe reconfiguration: disable the active divider, drain, pulse the divider reset with the new N loaded, then enable the even or odd divider.
- Guarantees that div_n never changes while either divider is enabled.

Parameters:
- SIZE, default `SIZE (from reg_size.v), width of divide factor.
- SETTLE_CYCLES, default 2, number of DRAIN cycles with both enables low before reset pulse; legal range 1..15.

Ports:
- clk  input  1  fast input clock, shared with the dividers
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  new divide factor offered
- req_n  input  SIZE  requested divide factor
- req_ready  output  1  block can accept a request this cycle
- div_n  output  SIZE  divide factor driven to both dividers
- div_reset  output  1  active-high reset to both dividers
- even_en  output  1  enable for even divider
- odd_en  output  1  enable for odd divider
- busy  output  1  reconfiguration in progress
- err  output  1  sticky flag: illegal request received
- err_clr  input  1  clears err
- bypass_sel  output  1  select undivided clk (see Optional Feature)

Behaviour:
- Reset values: req_ready=1, div_n=0, div_reset=1, even_en=0, odd_en=0, busy=0, err=0, bypass_sel=0, state=IDLE, settle counter=0.
- Asserting reset_n low in any state forces reset values immediately, including mid-sequence. Any in-flight request is dropped.
- States: IDLE, DRAIN, RST, RUN.
- IDLE: div_reset=1, both enables 0, req_ready=1.
- RUN: div_reset=0, exactly one enable high, req_ready=1.
- DRAIN and RST: req_ready=0, busy=1.
- Acceptance occurs at an edge where req_valid && req_ready.
- Legal request: req_n >= 2.
  - At acceptance edge k: div_n <= req_n; enables <= 0; counter <= SETTLE_CYCLES-1; state <= DRAIN.
  - Cycles k+1 .. k+SETTLE_CYCLES: DRAIN, counter decrements, div_reset unchanged.
  - Cycle k+SETTLE_CYCLES+1: RST, div_reset=1.
  - Cycle k+SETTLE_CYCLES+2: RUN, div_reset=0, even_en=~div_n[0], odd_en=div_n[0], busy=0, req_ready=1.
  - Total acceptance-to-enable latency: SETTLE_CYCLES+2 cycles.
- Illegal request (req_n 0 or 1 without macro): accepted (handshake completes), err<=1. State, div_n and enables are unchanged. A divider running in RUN continues undisturbed.
- Request equal to current div_n: full sequence still runs (restarts phase).
- err_clr and a new illegal request at the same edge: set wins, err=1.
- even_en and odd_en are never high simultaneously. Neither is high while div_reset=1 or during DRAIN.
- div_n only changes at acceptance edges and at reset.
- req_valid/req_n need not stay stable after acceptance. Sampled once.

Optional Feature:
- Macro: DIV_BYPASS_EN.
- Defined:
  - req_n == 1 is legal and runs the DRAIN/RST sequence.
  - In RUN it ends with both enables 0, div_reset=1, bypass_sel=1.
  - Any subsequent legal N>=2 clears bypass_sel at its acceptance edge.
  - req_n == 0 remains illegal.
- Undefined:
  - bypass_sel tied 0.
  - req_n == 1 is illegal and sets err.

Test Plan:
- Reset, then req_n=6 accepted at edge k with SETTLE_CYCLES=2 -> div_reset=1 at k+3; even_en=1, odd_en=0, div_n=6, busy=0 at k+4; req_ready low k+1..k+3.
- Running with N=6, request req_n=7 -> even_en drops at k+1, no cycle with both enables high, div_reset pulse one cycle, odd_en=1 at k+4, div_n=7.
- In RUN with N=4, request req_n=0 -> err=1 next cycle, even_en stays 1, div_n stays 4. Then err_clr=1 together with req_n=1 (macro off) -> err remains 1.
- reset_n low during DRAIN -> all outputs at reset values immediately. After release: IDLE, req_ready=1, div_reset=1.
- req_valid held high while busy with changing req_n -> only the value at the acceptance edge reaches div_n; next request accepted first cycle req_ready=1.
- With DIV_BYPASS_EN: req_n=1 -> bypass_sel=1, both enables 0 at k+4. Then req_n=5 -> bypass_sel=0 at acceptance edge, odd_en=1 at k+4.
